// File: rtl/osc_freq_counter.sv
// rtl/osc_freq_counter.sv - gated rising-edge counter for an asynchronous oscillator input (optional glitch filter: OSC_FREQ_COUNTER_GLITCH_FILTER_EN)
module osc_freq_counter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             busy,
  output logic             overflow
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;

  // Window counter counts down from GATE_CYCLES-1 to 0, giving GATE_CYCLES measuring cycles.
  localparam logic [15:0]      WIN_LOAD = 16'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACC_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ACC_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;
  logic det_in;
  logic edge_stb;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [15:0]      win_q, win_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [CNT_W-1:0] acc_next;
  logic             acc_ovf_next;

`ifdef OSC_FREQ_COUNTER_GLITCH_FILTER_EN
  logic filt_a_q, filt_a_d;
  logic filt_b_q, filt_b_d;
  logic filt_q, filt_d;

  // Majority of the current and two previous synchronized samples; an isolated
  // one-cycle high or low sample can never win the vote. The registered vote
  // adds the second cycle of filter latency.
  always_comb begin
    filt_a_d = sync2_q;
    filt_b_d = filt_a_q;
    filt_d   = (sync2_q & filt_a_q) | (sync2_q & filt_b_q) | (filt_a_q & filt_b_q);
  end

  // Filter history and voted output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_a_q <= 1'b0;
      filt_b_q <= 1'b0;
      filt_q   <= 1'b0;
    end else begin
      filt_a_q <= filt_a_d;
      filt_b_q <= filt_b_d;
      filt_q   <= filt_d;
    end
  end

  assign det_in = filt_q;
`else
  assign det_in = sync2_q;
`endif

  // Two-flop synchronizer followed by the edge-detector history flop.
  always_comb begin
    sync1_d  = osc_in;
    sync2_d  = sync1_q;
    sync3_d  = det_in;
    edge_stb = det_in & ~sync3_q;
  end

  // Synchronizer and edge-detector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  // Saturating accumulate; an edge arriving at full scale only marks overflow.
  always_comb begin
    acc_next     = acc_q;
    acc_ovf_next = acc_ovf_q;
    if (edge_stb) begin
      if (acc_q == ACC_MAX) begin
        acc_ovf_next = 1'b1;
      end else begin
        acc_next = acc_q + ACC_ONE;
      end
    end
  end

  // Measurement FSM: idle, count over the gate window, then hold result until ack.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    win_d     = win_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    valid_d   = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_MEASURE;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          win_d     = WIN_LOAD;
        end
      end
      ST_MEASURE: begin
        acc_d     = acc_next;
        acc_ovf_d = acc_ovf_next;
        if (win_q == 16'd0) begin
          // The final window cycle's edge is folded straight into the result.
          state_d = ST_DONE;
          count_d = acc_next;
          ovf_d   = acc_ovf_next;
          valid_d = 1'b1;
        end else begin
          win_d = win_q - 16'd1;
        end
      end
      ST_DONE: begin
        // start is deliberately not looked at here, so start+ack is just ack.
        if (ack) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, accumulator and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      win_q     <= 16'd0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      win_q     <= win_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
    end
  end

  assign count    = count_q;
  assign valid    = valid_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == ST_MEASURE);

endmodule

// File: tb/tb_osc_freq_counter.sv
// tb/tb_osc_freq_counter.sv - directed self-checking bench for osc_freq_counter
module tb_osc_freq_counter;

  logic        clk = 1'b0;
  logic        rst, osc, start, ack;
  logic [15:0] count;
  logic        valid, busy, overflow;
  logic [3:0]  count_s;
  logic        valid_s, busy_s, overflow_s;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  osc_freq_counter #(.GATE_CYCLES(100), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start), .ack(ack),
    .count(count), .valid(valid), .busy(busy), .overflow(overflow)
  );

  osc_freq_counter #(.GATE_CYCLES(100), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .osc_in(osc), .start(start), .ack(ack),
    .count(count_s), .valid(valid_s), .busy(busy_s), .overflow(overflow_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // osc level to drive before posedge i of the window (i=1 is the first measuring edge)
  function automatic logic pat(input int mode, input int i);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (i % 2) == 1;
      3:       return (i % 4) >= 2;
      default: return (i >= 10) && (i <= 82) && (((i - 10) % 8) == 0);
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Pulses start, then runs n window cycles sampling busy/valid before each edge.
  task automatic run_window(input int mode, input int n, input int start_at,
                            output int busy_cnt, output int valid_cnt);
    busy_cnt  = 0;
    valid_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      busy_cnt  += int'(busy);
      valid_cnt += int'(valid);
      start = (i == start_at);
      osc   = pat(mode, i);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, vc, c0, bsum;
    rst = 1'b1; start = 1'b0; ack = 1'b0; osc = 1'b0;
    idle(3);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;
    idle(1);

    // ack outside DONE does nothing
    pulse_ack();
    chk("idle_ack_valid", 32'(valid), 0);
    chk("idle_ack_busy", 32'(busy), 0);
    idle(8);

    // period-4 oscillator, stray start mid-window
    run_window(3, 100, 50, bc, vc);
    chk("p4_busy_cycles", 32'(bc), 100);
    chk("p4_early_valid", 32'(vc), 0);
    @(negedge clk);
    chk("p4_valid", 32'(valid), 1);
    chk("p4_busy_done", 32'(busy), 0);
    chk("p4_overflow", 32'(overflow), 0);
    chk("p4_count_25pm1", 32'((count >= 16'd24) && (count <= 16'd26)), 1);
    c0 = int'(count);
    osc = 1'b0;
    idle(3);
    chk("p4_hold_valid", 32'(valid), 1);
    chk("p4_hold_count", 32'(count), 32'(c0));

    // start together with ack in DONE is ack only
    start = 1'b1; ack = 1'b1;
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    chk("sa_valid", 32'(valid), 0);
    chk("sa_busy", 32'(busy), 0);
    bsum = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bsum += int'(busy);
    end
    chk("sa_no_restart", 32'(bsum), 0);
    chk("sa_count_kept", 32'(count), 32'(c0));

    // constant high oscillator
    osc = 1'b1;
    idle(8);
    run_window(1, 100, 0, bc, vc);
    @(negedge clk);
    chk("hi_count", 32'(count), 0);
    chk("hi_overflow", 32'(overflow), 0);
    chk("hi_valid", 32'(valid), 1);
    idle(5);
    chk("hi_valid_held", 32'(valid), 1);
    pulse_ack();
    chk("hi_ack_valid", 32'(valid), 0);
    chk("hi_ack_count", 32'(count), 0);
    osc = 1'b0;
    idle(8);

    // period-2 oscillator: 4-bit instance saturates
    run_window(2, 100, 0, bc, vc);
    @(negedge clk);
    chk("p2_s_count", 32'(count_s), 15);
    chk("p2_s_overflow", 32'(overflow_s), 1);
    chk("p2_s_valid", 32'(valid_s), 1);
    chk("p2_count_range", 32'((count >= 16'd48) && (count <= 16'd50)), 1);
    chk("p2_overflow", 32'(overflow), 0);
    pulse_ack();
    osc = 1'b0;
    idle(8);

    // reset 50 cycles into the window
    run_window(3, 50, 0, bc, vc);
    chk("ab_busy_cycles", 32'(bc), 50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_valid", 32'(valid), 0);
    chk("ab_count", 32'(count), 0);
    chk("ab_overflow_s", 32'(overflow_s), 0);
    osc = 1'b0;
    idle(8);
    run_window(3, 100, 0, bc, vc);
    chk("ab2_busy_cycles", 32'(bc), 100);
    @(negedge clk);
    chk("ab2_valid", 32'(valid), 1);
    chk("ab2_count_25pm1", 32'((count >= 16'd24) && (count <= 16'd26)), 1);
    pulse_ack();
    osc = 1'b0;
    idle(8);

    // ten isolated one-cycle high glitches
    run_window(4, 100, 0, bc, vc);
    @(negedge clk);
`ifdef OSC_FREQ_COUNTER_GLITCH_FILTER_EN
    chk("gl_count", 32'(count), 0);
    chk("gl_count_s", 32'(count_s), 0);
`else
    chk("gl_count", 32'(count), 10);
    chk("gl_count_s", 32'(count_s), 10);
`endif
    chk("gl_overflow", 32'(overflow), 0);
    chk("gl_valid", 32'(valid), 1);
    pulse_ack();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osc_freq_counter.md
OSC_FREQ_COUNTER -- requirements
Module: osc_freq_counter

Interface
REQ-001 Parameter GATE_CYCLES, default 1000: measurement window length in clk cycles, legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: width of the edge count result.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port osc_in, input, 1: asynchronous free-running oscillator or latch output (e.g. inout q of the loop stage), unrelated to clk.
REQ-006 Port start, input, 1: one-cycle request to begin a measurement.
REQ-007 Port ack, input, 1: consumer acknowledges the held result.
REQ-008 Port count, output, CNT_W: rising edges of osc_in counted in the last window.
REQ-009 Port valid, output, 1: count holds a completed result.
REQ-010 Port busy, output, 1: measurement window in progress.
REQ-011 Port overflow, output, 1: count saturated during the last window.

Function
REQ-012 osc_in SHALL pass through a 2-flop synchronizer, then a third flop; the edge strobe SHALL be sync2 & ~sync3 (rising edges only).
REQ-013 The FSM SHALL have states IDLE, MEASURE, DONE; reset state IDLE.
REQ-014 IDLE: start=1 -> MEASURE next cycle, with the edge accumulator cleared and the window counter loaded with GATE_CYCLES-1.
REQ-015 MEASURE SHALL last exactly GATE_CYCLES clk cycles; each cycle the accumulator SHALL increment when the edge strobe is 1.
REQ-016 The accumulator SHALL saturate at 2^CNT_W-1; an increment attempted at saturation SHALL set the overflow flag for that window.
REQ-017 The window counter reaching 0 in MEASURE SHALL cause a transition to DONE next cycle; an edge strobe in that final cycle SHALL be counted.
REQ-018 On entry to DONE, count and overflow SHALL be loaded from the accumulator, valid SHALL be 1, and both SHALL be held stable until ack.
REQ-019 DONE: ack=1 -> IDLE next cycle, with valid cleared; count and overflow SHALL retain their last values.
REQ-020 start SHALL be ignored in MEASURE and DONE; start with ack in the same DONE cycle SHALL be treated as ack only.
REQ-021 ack SHALL be ignored outside DONE.
REQ-022 busy SHALL be 1 exactly while the state is MEASURE.
REQ-023 Result latency SHALL be GATE_CYCLES+1 clk from the start cycle to valid=1.

Reset
REQ-024 rst=1 SHALL force the state to IDLE and clear count, valid, busy, overflow, the accumulator, the window counter and all synchronizer/filter flops on the next clk edge.
REQ-025 rst asserted mid-MEASURE or in DONE SHALL abort the operation and discard the result; rst SHALL take priority over start and ack.

Configuration
REQ-026 With macro OSC_FREQ_COUNTER_GLITCH_FILTER_EN defined, a 3-sample majority filter SHALL sit between sync2 and the edge detector, adding 2 clk of input latency and rejecting high or low pulses of 1 clk.
REQ-027 Without OSC_FREQ_COUNTER_GLITCH_FILTER_EN, the edge detector SHALL operate directly on sync2, with no filter flops present.

Verification
REQ-028 GATE_CYCLES=100, osc_in period 4 clk (50% duty), start pulse -> valid after 101 clk, count=25 (+/-1), overflow=0, busy high for 100 clk.
REQ-029 osc_in held constant 1, start -> count=0, overflow=0, valid=1 until ack; ack -> valid=0 next cycle, count still 0.
REQ-030 CNT_W=4, GATE_CYCLES=100, osc_in period 2 clk -> count=15, overflow=1.
REQ-031 rst asserted 50 clk into MEASURE -> next cycle busy=0, valid=0, count=0; a later start gives a normal full-window result.
REQ-032 In DONE, start and ack in the same cycle -> IDLE, no new measurement, busy stays 0; start in MEASURE -> no effect on window length.
REQ-033 Filter enabled, 1-clk-wide high glitches on otherwise-low osc_in -> count=0; filter disabled, same stimulus -> count equals the number of glitches sampled high.
